// File: rtl/keycode_event_queue.sv
// Turns the held-keycode level from the PIO into a FIFO of press/release events.
// The keycode is debounced, the accepted key is tracked, and events leave through a valid/ready port.
module keycode_event_queue #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [7:0]               keycode,
    input  logic                     ev_ready,
    input  logic                     clear_ovf,
    output logic [7:0]               held_code,
    output logic                     ev_valid,
    output logic [7:0]               ev_code,
    output logic                     ev_press,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [PW:0]   FULL    = DEPTH[PW:0];

    typedef enum logic [1:0] {
        IDLE,
        PUSH_REL,
        PUSH_PRS
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      cand_q, cand_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      held_q, held_d;
    logic [7:0]      old_q, old_d;
    logic [8:0]      mem_q [DEPTH];
    logic [8:0]      mem_d [DEPTH];
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            push;
    logic [8:0]      push_data;
    logic            pop;
    logic            push_ok;

    // Stability filter and event sequencer; the filter keeps counting while events are pushed.
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        old_d     = old_q;
        state_d   = state_q;
        push      = 1'b0;
        push_data = '0;

        if (keycode != cand_q) begin
            cand_d = keycode;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cnt_q == CNT_MAX && keycode == cand_q && cand_q != held_q) begin
                    held_d  = cand_q;
                    old_d   = held_q;
                    state_d = (held_q != '0) ? PUSH_REL : PUSH_PRS;
                end
            end
            PUSH_REL: begin
                push      = 1'b1;
                push_data = {old_q, 1'b0};
                state_d   = (held_q != '0) ? PUSH_PRS : IDLE;
            end
            PUSH_PRS: begin
                push      = 1'b1;
                push_data = {held_q, 1'b1};
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    always_comb begin
        pop     = (count_q != '0) && ev_ready;
        push_ok = push && ((count_q != FULL) || pop);
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (push_ok) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            held_q  <= '0;
            old_q   <= '0;
            mem_q   <= '{default: '0};
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            old_q   <= old_d;
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign held_code           = held_q;
    assign ev_valid            = (count_q != '0);
    assign {ev_code, ev_press} = mem_q[rd_q];
    assign ev_count            = count_q;
    assign overflow            = ovf_q;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Bench for keycode_event_queue: run-length/queue reference model feeding a scoreboard,
// a negedge monitor, directed scenarios and a randomized phase.
module tb_keycode_event_queue;

    localparam int DEPTH = 8;
    localparam int S     = 4;

    typedef logic [8:0] ev_t;   // {code, press}

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] kc    = '0;
    logic       rdy   = 1'b0;
    logic       clr   = 1'b0;

    logic [7:0] held_code;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_press;
    logic [3:0] ev_count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    keycode_event_queue #(
        .DEPTH         (DEPTH),
        .STABLE_CYCLES (S)
    ) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .keycode   (kc),
        .ev_ready  (rdy),
        .clear_ovf (clr),
        .held_code (held_code),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_press  (ev_press),
        .ev_count  (ev_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a key is accepted once the same value has been sampled on
    // S+1 consecutive edges while no earlier change is still being emitted; each
    // change yields release(old) then press(new), one event per edge.
    int         run_len;
    logic [7:0] run_val;
    logic [7:0] m_held;
    bit         m_ovf;
    bit         dropped;
    ev_t        e;
    ev_t        pend[$];
    ev_t        mfifo[$];
    ev_t        sb_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_val = '0;
            run_len = 1;
            m_held  = '0;
            m_ovf   = 1'b0;
            pend.delete();
            mfifo.delete();
            sb_q.delete();
        end else begin
            dropped = 1'b0;
            if (mfifo.size() > 0 && rdy) void'(mfifo.pop_front());
            if (kc == run_val) run_len++;
            else begin
                run_val = kc;
                run_len = 1;
            end
            if (pend.size() > 0) begin
                e = pend.pop_front();
                if (mfifo.size() < DEPTH) begin
                    mfifo.push_back(e);
                    sb_q.push_back(e);
                end else begin
                    dropped = 1'b1;
                end
            end else if (run_len >= S + 1 && kc != m_held) begin
                if (m_held != 0) pend.push_back({m_held, 1'b0});
                if (kc != 0)     pend.push_back({kc, 1'b1});
                m_held = kc;
            end
            if (dropped)  m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
    end

    // Monitor: compares registered outputs half a cycle after each edge and
    // retires the scoreboard head when the upcoming edge will pop it.
    always @(negedge clk) begin
        chk("held_code", held_code, m_held);
        chk("ev_count", ev_count, mfifo.size());
        chk("overflow", overflow, m_ovf);
        chk("ev_valid", ev_valid, sb_q.size() != 0);
        if (ev_valid && sb_q.size() > 0) begin
            chk("ev_head", {ev_code, ev_press}, sb_q[0]);
            if (rdy) void'(sb_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        kc = v;
        tick(n);
    endtask

    task automatic drain(input int n);
        rdy = 1'b1;
        tick(n);
        rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    ev_t        tbl5[8];
    logic [7:0] seq5[6];
    logic [7:0] pick[7];

    initial begin
        tbl5 = '{{8'h04,1'b1}, {8'h04,1'b0}, {8'h05,1'b1}, {8'h05,1'b0},
                 {8'h06,1'b1}, {8'h06,1'b0}, {8'h07,1'b1}, {8'h07,1'b0}};
        seq5 = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
        pick = '{8'h00, 8'h00, 8'h04, 8'h05, 8'h16, 8'h1A, 8'h00};

        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("rst_held", held_code, 0);
        chk("rst_valid", ev_valid, 0);
        chk("rst_count", ev_count, 0);

        // Single press: exact edge latency
        kc = 8'h04;
        tick(S);
        chk("press_held_before", held_code, 8'h00);
        tick(1);
        chk("press_held_edge", held_code, 8'h04);
        chk("press_valid_before", ev_valid, 0);
        tick(1);
        chk("press_valid_edge", ev_valid, 1);
        chk("press_code", ev_code, 8'h04);
        chk("press_type", ev_press, 1);
        chk("press_count", ev_count, 1);
        tick(8);
        chk("press_no_more", ev_count, 1);

        // Key switch: release then press on consecutive edges
        kc = 8'h16;
        tick(S + 1);
        chk("switch_held", held_code, 8'h16);
        chk("switch_count_e5", ev_count, 1);
        tick(1);
        chk("switch_count_e6", ev_count, 2);
        tick(1);
        chk("switch_count_e7", ev_count, 3);
        drain(4);
        chk("switch_drained", ev_count, 0);

        // Glitch rejection
        hold(8'h00, 10);
        drain(2);
        hold(8'h1A, S - 1);
        hold(8'h00, 10);
        chk("glitch_held", held_code, 8'h00);
        chk("glitch_count", ev_count, 0);
        hold(8'h1A, 10);
        chk("stable_held", held_code, 8'h1A);
        chk("stable_count", ev_count, 1);
        drain(2);
        hold(8'h00, 10);
        drain(2);

        // Asynchronous reset mid-cycle with queued events
        hold(8'h04, 8);
        hold(8'h05, 8);
        chk("prereset_count", ev_count, 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_held", held_code, 0);
        chk("async_valid", ev_valid, 0);
        chk("async_count", ev_count, 0);
        chk("async_code", ev_code, 0);
        chk("async_press", ev_press, 0);
        kc = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(10);
        chk("postreset_valid", ev_valid, 0);

        // Overflow: 10 events into 8 entries
        for (int i = 0; i < 6; i++) hold(seq5[i], 8);
        chk("ovf_count", ev_count, 8);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_order", {ev_code, ev_press}, tbl5[i]);
            drain(1);
        end
        chk("ovf_empty", ev_count, 0);
        chk("ovf_sticky", overflow, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full queue: push and pop on the same edge
        do_reset();
        for (int i = 0; i < 4; i++) hold(seq5[i], 8);
        hold(8'h00, 8);
        chk("full_count", ev_count, 8);
        kc = 8'h09;
        tick(S + 1);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        chk("full_pp_count", ev_count, 8);
        chk("full_pp_ovf", overflow, 0);
        drain(12);
        chk("full_drained", ev_count, 0);

        // Randomized phase
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int unsigned len;
            int unsigned bias;
            len  = $urandom_range(1, 10);
            bias = $urandom_range(0, 3);
            if ($urandom_range(0, 5) == 0) kc = 8'($urandom);
            else                           kc = pick[$urandom_range(0, 6)];
            repeat (len) begin
                rdy = ($urandom_range(0, 3) < bias);
                clr = ($urandom_range(0, 19) == 0);
                tick(1);
            end
        end
        clr = 1'b0;
        drain(20);
        chk("final_empty", ev_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
